eth_tx_arbiter: RTL
===================

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 The block SHALL have parameter IFG_BYTES, default 12, giving the minimum inter-frame gap in byte times.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock: the RGMII receive-derived clock that also drives the TX DDR stage.
REQ-003 The block SHALL have port i_rst, input, 1, reset: synchronous and active-high.
REQ-004 The block SHALL have port i_speed1000, input, 1: 1 means gigabit, 0 means 10/100.
REQ-005 The block SHALL have port i_req, input, 3: per-source frame request, where 0=ARP, 1=ICMP, 2=UDP.
REQ-006 The block SHALL have port i_data, input, 24: byte of source k on bits [8k+7:8k].
REQ-007 The block SHALL have port i_valid, input, 3: per-source byte valid.
REQ-008 The block SHALL have port i_last, input, 3: per-source last-byte flag, qualified by i_valid.
REQ-009 The block SHALL have port o_grant, output, 3: one-hot grant, all zero when no source is granted.
REQ-010 The block SHALL have port o_ready, output, 3: per-source byte accept strobe.
REQ-011 The block SHALL have port o_tx_data, output, 8: byte to the RGMII TX interface.
REQ-012 The block SHALL have port o_tx_valid, output, 1: byte valid to the RGMII TX interface.
REQ-013 The block SHALL have port o_busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, GRANT, XFER and GAP.
REQ-015 In IDLE with any i_req bit high, the FSM SHALL move to GRANT, and o_grant SHALL go one-hot on the next cycle.
REQ-016 The winner SHALL be chosen round-robin: search starts at pointer p; p resets to 0; after granting source k, p becomes (k+1) mod 3.
REQ-017 i_speed1000 SHALL be latched on entry to GRANT into a mode bit m, and SHALL be ignored until the next IDLE.
REQ-018 The byte time k SHALL be 1 cycle when m=1 and 2 cycles when m=0.
REQ-019 GRANT SHALL last one cycle, then the FSM SHALL move to XFER with the byte phase bit cleared.
REQ-020 In XFER with m=1, o_ready of the granted source SHALL be high every cycle.
REQ-021 In XFER with m=0, o_ready SHALL be high only on cycles where phase=0, and phase SHALL toggle every cycle.
REQ-022 A byte SHALL be accepted on a cycle where o_ready and i_valid of the granted source are both high.
REQ-023 An accepted byte SHALL appear on o_tx_data with o_tx_valid=1 on the next cycle, and SHALL be held for k cycles.
REQ-024 o_ready and o_grant bits of non-granted sources SHALL be 0 at all times.
REQ-025 Frame end SHALL occur on an accepted byte with i_last=1, or on a ready cycle where i_valid=0 (underrun: the frame is truncated and no byte is emitted).
REQ-026 At frame end, the FSM SHALL enter GAP, clear o_grant and load the gap counter with IFG_BYTES*k.
REQ-027 The gap counter SHALL count down only while o_tx_valid=0, and the FSM SHALL return to IDLE when it reaches 0.
REQ-028 o_tx_valid low time between frames SHALL be at least IFG_BYTES*k cycles, and at most IFG_BYTES*k+3 cycles when the next request is already pending and its source is valid on grant.
REQ-029 Deassertion of i_req by the granted source during XFER SHALL be ignored; the frame ends only per REQ-025.
REQ-030 A request arriving during GAP SHALL be held pending and arbitrated in IDLE; no request SHALL be lost.
REQ-031 o_tx_data SHALL be 0 whenever o_tx_valid=0.
REQ-032 A change of i_speed1000 outside IDLE SHALL NOT alter the byte cadence of the frame in progress.

Reset
REQ-033 While i_rst=1, the outputs SHALL be o_grant=0, o_ready=0, o_tx_data=0, o_tx_valid=0, o_busy=0.
REQ-034 While i_rst=1, the internal state SHALL be FSM=IDLE, p=0, gap counter=0, phase=0.
REQ-035 Reset mid-frame SHALL force the REQ-033/034 values on the next edge, with no partial gap enforced after release.

Verification
REQ-036 Bench scenario, gigabit single source: i_speed1000=1, source 2 sends 64 bytes 0x00..0x3F -> o_tx_valid high 64 consecutive cycles, bytes in order, each byte 1 cycle after acceptance.
REQ-037 Bench scenario, 10/100: i_speed1000=0, source 0 sends 0xA5,0x5A with last on 0x5A -> each byte held 2 cycles, and o_ready strobes on alternate cycles.
REQ-038 Bench scenario, contention: all three i_req high from reset -> grant order 0,1,2,0; each frame is preceded by a gap of 12..15 low cycles (m=1) or 24..27 low cycles (m=0).
REQ-039 Bench scenario, underrun: source 1 drops i_valid after byte 10 -> frame ends with 10 bytes, FSM enters GAP and the next grant follows rule REQ-028.
REQ-040 Bench scenario, speed toggle: i_speed1000 toggled mid-frame -> the cadence of the current frame is unchanged, and the next frame uses the new speed.
REQ-041 Bench scenario, reset: i_rst pulsed during XFER -> all outputs 0 next cycle, p=0, and the next request is granted to the lowest-index requester.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter for three frame sources into one RGMII TX byte stream, with 1G/10-100 byte pacing
// and an enforced inter-frame gap; source bytes are handed over by o_ready/i_valid, output is one cycle later.
module eth_tx_arbiter #(
  parameter int IFG_BYTES = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_speed1000,
  input  logic [2:0]  i_req,
  input  logic [23:0] i_data,
  input  logic [2:0]  i_valid,
  input  logic [2:0]  i_last,
  output logic [2:0]  o_grant,
  output logic [2:0]  o_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  output logic        o_busy
);

  localparam int GAP_W = $clog2(2 * IFG_BYTES + 2);
  localparam logic [GAP_W-1:0] GAP_1G  = GAP_W'(IFG_BYTES);
  localparam logic [GAP_W-1:0] GAP_100 = GAP_W'(2 * IFG_BYTES);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       sel_q;
  logic             mode_q;
  logic             phase_q;
  logic             hold_q;
  logic [GAP_W-1:0] gap_q;
  logic [2:0]       grant_q;
  logic [2:0]       ready_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;

  logic [2:0] req_rot;
  logic [1:0] win_off;
  logic [2:0] win_sum;
  logic [1:0] sel_d;
  logic [1:0] ptr_d;

  // Rotate requests so bit 0 is the source the pointer names, then take the first one set.
  always_comb begin
    case (ptr_q)
      2'd1:    req_rot = {i_req[0], i_req[2], i_req[1]};
      2'd2:    req_rot = {i_req[1], i_req[0], i_req[2]};
      default: req_rot = i_req;
    endcase
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else                 win_off = 2'd2;
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    sel_d   = (win_sum >= 3'd3) ? 2'(win_sum - 3'd3) : win_sum[1:0];
    ptr_d   = (sel_d == 2'd2) ? 2'd0 : sel_d + 2'd1;
  end

  logic       sel_vld;
  logic       sel_last;
  logic [7:0] sel_dat;
  logic       ready_cyc;
  logic       accept;
  logic       frame_end;

  always_comb begin
    case (sel_q)
      2'd1: begin
        sel_vld  = i_valid[1];
        sel_last = i_last[1];
        sel_dat  = i_data[15:8];
      end
      2'd2: begin
        sel_vld  = i_valid[2];
        sel_last = i_last[2];
        sel_dat  = i_data[23:16];
      end
      default: begin
        sel_vld  = i_valid[0];
        sel_last = i_last[0];
        sel_dat  = i_data[7:0];
      end
    endcase
    ready_cyc = |ready_q;
    accept    = ready_cyc & sel_vld;
    frame_end = ready_cyc & (~sel_vld | sel_last);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      mode_q     <= 1'b0;
      phase_q    <= 1'b0;
      hold_q     <= 1'b0;
      gap_q      <= '0;
      grant_q    <= 3'b000;
      ready_q    <= 3'b000;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      // In 10/100 mode each byte stays on the wire for a second cycle.
      if (accept) begin
        tx_data_q  <= sel_dat;
        tx_valid_q <= 1'b1;
        hold_q     <= ~mode_q;
      end else if (hold_q) begin
        hold_q <= 1'b0;
      end else begin
        tx_data_q  <= 8'h00;
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|i_req) begin
            state_q <= GRANT;
            grant_q <= 3'b001 << sel_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            mode_q  <= i_speed1000;
          end
        end
        GRANT: begin
          state_q <= XFER;
          phase_q <= 1'b0;
          ready_q <= grant_q;
        end
        XFER: begin
          if (frame_end) begin
            state_q <= GAP;
            grant_q <= 3'b000;
            ready_q <= 3'b000;
            phase_q <= 1'b0;
            gap_q   <= mode_q ? GAP_1G : GAP_100;
          end else begin
            phase_q <= mode_q ? 1'b0 : ~phase_q;
            ready_q <= (mode_q || phase_q) ? grant_q : 3'b000;
          end
        end
        GAP: begin
          // Leave on the final count so the IDLE/GRANT overhead fits inside the gap slack.
          if (gap_q == '0) begin
            state_q <= IDLE;
          end else if (!tx_valid_q) begin
            gap_q <= gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_grant    = grant_q;
  assign o_ready    = ready_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_busy     = (state_q != IDLE);

endmodule
